coproc_arith_unit: RTL and testbench
====================================

Name: coproc_arith_unit

Overview:
Iterative integer arithmetic engine sitting directly downstream of the bus-side coprocessor bridge. It consumes the bridge's start strobe and 24-bit command word, and computes one of three operations over a fixed 12-cycle schedule: multiply, divide or square root. It returns the 24-bit result with a single-cycle ready pulse, which the bridge posts to the bus and turns into an interrupt.

Parameters:
REARM, 1, 1 = a new command is accepted only after mstart has been low for at least one cycle since the last acceptance; 0 = accept whenever IDLE.
DIV0_QUO, 11'h7FF, quotient returned on divide-by-zero.

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous, active-high reset
mstart  in  1  command strobe from bridge; level, may stay high for many cycles
min  in  24  command word: [23:22] op, [21:11] a, [10:0] b
mrdy  out  1  result-valid pulse, exactly one cycle per accepted command
mout  out  24  result word, registered, held until the next result
busy  out  1  high from the acceptance cycle until the mrdy cycle inclusive

Behaviour:
- Reset (async, any state): state=IDLE, mrdy=0, mout=0, busy=0, rearm flag cleared (ready to accept). A command in flight is discarded and no mrdy is produced.
- Op codes:
  - 00 MUL: unsigned a*b, 22-bit product, mout={2'b0, prod}.
  - 01 DIV: unsigned restoring a/b, mout={1'b0, 1'b0, rem[10:0], quo[10:0]}.
  - 10 SQRT: radicand R={a,b}, 22 bits unsigned; root[10:0]=floor(sqrt R), rem=R-root^2 (12 bits); mout={1'b0, rem[11:0], root[10:0]}.
  - 11 reserved: mout=24'h800000.
- Divide by zero (op 01, b==0): mout={1'b1, 1'b0, a, DIV0_QUO}.
- Acceptance: at clock edge E0, when state==IDLE, mstart==1 and (REARM==0 or the rearm flag is clear).
  - Operands and op are latched at E0; min is ignored afterwards.
- State machine: IDLE -> RUN (11 iterations, edges E1..E11) -> DONE (edge E12) -> IDLE.
  - mrdy=1 and mout valid during the cycle after E12; mrdy returns to 0 at E13.
- Per-iteration datapath:
  - MUL: shift-add, one multiplier bit per iteration, LSB first.
  - DIV: one quotient bit per iteration, MSB first.
  - SQRT: two radicand bits per iteration, non-restoring.
- Latency is fixed at 12 cycles for every op, including reserved and divide-by-zero (counter still runs).
- mstart while busy is ignored: no queueing, no restart, latched operands unaffected.
- REARM=1: the rearm flag is set on acceptance and cleared on any cycle with mstart==0.
  - A level held high across completion does not re-trigger.
  - mstart may fall before mrdy; the flag is then already clear on return to IDLE.
- mout changes only at the E12 edge (or reset). mrdy is never high for two consecutive cycles.
- Iteration counter is 4 bits and saturates at the RUN->DONE transition; it never wraps.

Decomposition:
- Shared package (coproc_pkg):
  - op codes OP_MUL/OP_DIV/OP_SQRT/OP_RSV
  - field positions OP_HI=23, A_LSB=11, B_LSB=0
  - ITER=11
  - state encoding IDLE/RUN/DONE
  - ERR_BIT=23
- Single module; one shared accumulator/shift register pair multiplexed by the latched op. No sub-module is needed.

Test Plan:
- MUL, a=2047, b=2047, one-cycle mstart -> single mrdy 12 cycles after acceptance, mout=24'h3FF001; busy high for 13 cycles.
- DIV, a=100, b=7 -> mout=24'h00100E (rem 2, quo 14). DIV, a=5, b=0 -> mout=24'h802FFF.
- SQRT, a=488, b=576 (R=1000000) -> mout=24'h0003E8. SQRT, a=0, b=10 -> mout=24'h000803.
- mstart held high for 40 cycles with MUL 3*4, REARM=1 -> exactly one mrdy, mout=24'h00000C. Same stimulus with REARM=0 -> mrdy every 13 cycles.
- Mid-computation, drive mstart with a different min; then assert rst for 1 cycle at E6 of a DIV -> the first command's result is unaffected by the second min; after reset, mrdy=0, mout=0, no mrdy follows, and the next command is accepted normally.
- op=11 with arbitrary operands -> mout=24'h800000 after 12 cycles; mout then holds until the next result.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor arithmetic unit: op codes, command
// word field positions, iteration count and FSM state encoding.
package coproc_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned OP_HI   = 23;
  localparam int unsigned A_LSB   = 11;
  localparam int unsigned B_LSB   = 0;
  localparam int unsigned ITER    = 11;
  localparam int unsigned ERR_BIT = 23;

endpackage

// File: rtl/coproc_arith_unit.sv
// Iterative multiply / divide / square-root engine with a fixed 12-cycle
// schedule, sharing one accumulator + shift register pair across all ops.
module coproc_arith_unit
  import coproc_pkg::*;
#(
  parameter bit          REARM    = 1'b1,
  parameter logic [10:0] DIV0_QUO = 11'h7FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mstart,
  input  logic [23:0] min,
  output logic        mrdy,
  output logic [23:0] mout,
  output logic        busy
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [21:0] sh_q, sh_d;
  logic [10:0] opnd_q, opnd_d;
  logic        rearm_q, rearm_d;
  logic        mrdy_q, mrdy_d;
  logic        busy_q, busy_d;
  logic [23:0] mout_q, mout_d;

  logic        accept;
  logic [10:0] a_in, b_in;
  op_e         op_in;
  logic [11:0] mul_sum, div_t, sq_rem;
  logic        div_ge;
  logic [15:0] sq_sh, sq_new;
  logic [23:0] result;

  // Datapath: per-iteration step values and the final result formatting.
  always_comb begin
    a_in    = min[A_LSB +: 11];
    b_in    = min[B_LSB +: 11];
    op_in   = op_e'(min[OP_HI -: 2]);
    accept  = (state_q == IDLE) && mstart && (!REARM || !rearm_q);

    mul_sum = {1'b0, acc_q[10:0]} + (sh_q[0] ? {1'b0, opnd_q} : 12'd0);
    div_t   = {acc_q[10:0], sh_q[10]};
    div_ge  = div_t >= {1'b0, opnd_q};
    sq_sh   = {acc_q[13:0], sh_q[21:20]};
    sq_new  = acc_q[15] ? sq_sh + {3'b0, opnd_q, 2'b11}
                        : sq_sh - {3'b0, opnd_q, 2'b01};
    sq_rem  = 12'(acc_q[15] ? acc_q + {4'b0, opnd_q, 1'b1} : acc_q);

    result = '0;
    case (op_q)
      OP_MUL:  result = {2'b0, acc_q[10:0], sh_q[10:0]};
      // With a zero divisor every step keeps the shifted-in dividend, so the
      // remainder register ends up holding the original a.
      OP_DIV: begin
        if (opnd_q == '0) begin
          result          = {2'b0, acc_q[10:0], DIV0_QUO};
          result[ERR_BIT] = 1'b1;
        end else begin
          result = {2'b0, acc_q[10:0], sh_q[10:0]};
        end
      end
      OP_SQRT: result = {1'b0, sq_rem, opnd_q};
      default: result[ERR_BIT] = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opnd_d  = opnd_q;
    mout_d  = mout_q;
    mrdy_d  = 1'b0;
    rearm_d = mstart ? (rearm_q | accept) : 1'b0;
    busy_d  = accept | (busy_q & ~mrdy_q);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          op_d    = op_in;
          cnt_d   = '0;
          acc_d   = '0;
          case (op_in)
            OP_DIV: begin
              sh_d   = {11'b0, a_in};
              opnd_d = b_in;
            end
            OP_SQRT: begin
              sh_d   = {a_in, b_in};
              opnd_d = '0;
            end
            default: begin
              sh_d   = {11'b0, b_in};
              opnd_d = a_in;
            end
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = DONE;
        case (op_q)
          OP_DIV: begin
            acc_d = {4'b0, div_ge ? div_t - {1'b0, opnd_q} : div_t};
            sh_d  = {11'b0, sh_q[9:0], div_ge};
          end
          OP_SQRT: begin
            acc_d  = sq_new;
            sh_d   = {sh_q[19:0], 2'b00};
            opnd_d = {opnd_q[9:0], ~sq_new[15]};
          end
          default: begin
            acc_d = {5'b0, mul_sum[11:1]};
            sh_d  = {11'b0, mul_sum[0], sh_q[10:1]};
          end
        endcase
      end
      DONE: begin
        state_d = IDLE;
        mrdy_d  = 1'b1;
        mout_d  = result;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
      rearm_q <= 1'b0;
      mrdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      mout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opnd_q  <= opnd_d;
      rearm_q <= rearm_d;
      mrdy_q  <= mrdy_d;
      busy_q  <= busy_d;
      mout_q  <= mout_d;
    end
  end

  assign mrdy = mrdy_q;
  assign mout = mout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_coproc_arith_unit.sv
// Directed self-checking bench for coproc_arith_unit (REARM=1 and REARM=0).
module tb_coproc_arith_unit;

  logic        clk = 1'b0;
  logic        rst, mstart, mstart_nr;
  logic [23:0] min;
  logic        mrdy, busy, mrdy_nr, busy_nr;
  logic [23:0] mout, mout_nr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  coproc_arith_unit #(.REARM(1'b1), .DIV0_QUO(11'h7FF)) dut (
    .clk(clk), .rst(rst), .mstart(mstart), .min(min),
    .mrdy(mrdy), .mout(mout), .busy(busy)
  );

  coproc_arith_unit #(.REARM(1'b0), .DIV0_QUO(11'h7FF)) dut_nr (
    .clk(clk), .rst(rst), .mstart(mstart_nr), .min(min),
    .mrdy(mrdy_nr), .mout(mout_nr), .busy(busy_nr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] cmd(input logic [1:0] op, input logic [10:0] a,
                                      input logic [10:0] b);
    return {op, a, b};
  endfunction

  task automatic wait_rdy(output int unsigned cycles, output int unsigned busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!mrdy && cycles < 30) begin
      tick();
      cycles++;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [23:0] word, input logic [23:0] exp);
    int unsigned cyc, bcyc;
    min    = word;
    mstart = 1'b1;
    tick();
    mstart = 1'b0;
    check({tag, "_accept"}, {23'b0, busy}, 24'd1);
    wait_rdy(cyc, bcyc);
    check({tag, "_lat"}, 24'(cyc), 24'd12);
    check({tag, "_busy_len"}, 24'(bcyc + 1), 24'd13);
    check({tag, "_mout"}, mout, exp);
    tick();
    check({tag, "_after"}, {22'b0, mrdy, busy}, 24'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned cyc, bcyc, pulses, pulses_nr, first_nr, last_nr, late;
    rst       = 1'b1;
    mstart    = 1'b0;
    mstart_nr = 1'b0;
    min       = '0;
    tick();
    tick();
    check("rst_ctl", {22'b0, mrdy, busy}, 24'd0);
    check("rst_mout", mout, 24'd0);
    rst = 1'b0;
    tick();

    run_cmd("mul_max", cmd(2'b00, 11'd2047, 11'd2047), 24'h3FF001);
    run_cmd("div", cmd(2'b01, 11'd100, 11'd7), 24'h00100E);
    run_cmd("div0", cmd(2'b01, 11'd5, 11'd0), 24'h802FFF);
    run_cmd("sqrt_1e6", cmd(2'b10, 11'd488, 11'd576), 24'h0003E8);
    run_cmd("sqrt_10", cmd(2'b10, 11'd0, 11'd10), 24'h000803);
    run_cmd("rsv", cmd(2'b11, 11'h123, 11'h456), 24'h800000);
    repeat (5) tick();
    check("rsv_hold", mout, 24'h800000);

    // Level held for 40 cycles: one result with rearm, a result every 13 without.
    min       = cmd(2'b00, 11'd3, 11'd4);
    mstart    = 1'b1;
    mstart_nr = 1'b1;
    pulses    = 0;
    pulses_nr = 0;
    first_nr  = 0;
    last_nr   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mrdy) pulses++;
      if (mrdy_nr) begin
        pulses_nr++;
        if (first_nr == 0) first_nr = i;
        last_nr = i;
      end
    end
    mstart    = 1'b0;
    mstart_nr = 1'b0;
    check("rearm_pulses", 24'(pulses), 24'd1);
    check("rearm_mout", mout, 24'h00000C);
    check("norearm_pulses", 24'(pulses_nr), 24'd3);
    check("norearm_first", 24'(first_nr), 24'd13);
    check("norearm_last", 24'(last_nr), 24'd39);
    check("norearm_mout", mout_nr, 24'h00000C);
    repeat (15) tick();

    // Second strobe during a DIV must be ignored.
    min    = cmd(2'b01, 11'd100, 11'd7);
    mstart = 1'b1;
    tick();
    mstart = 1'b0;
    tick();
    min    = cmd(2'b00, 11'd3, 11'd4);
    mstart = 1'b1;
    tick();
    mstart = 1'b0;
    min    = '0;
    wait_rdy(cyc, bcyc);
    check("ign_lat", 24'(cyc), 24'd10);
    check("ign_mout", mout, 24'h00100E);
    tick();
    check("ign_no_restart", {22'b0, mrdy, busy}, 24'd0);

    // Reset asserted at E6 of a DIV discards it.
    min    = cmd(2'b01, 11'd100, 11'd7);
    mstart = 1'b1;
    tick();
    mstart = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_ctl", {22'b0, mrdy, busy}, 24'd0);
    check("midrst_mout", mout, 24'd0);
    tick();
    rst  = 1'b0;
    late = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mrdy || busy) late++;
    end
    check("midrst_quiet", 24'(late), 24'd0);
    check("midrst_mout_hold", mout, 24'd0);
    run_cmd("post_rst", cmd(2'b10, 11'd488, 11'd576), 24'h0003E8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
